// File: rtl/astro_game_ctrl.sv
// Astro Barrier game sequencer: level FSM, fire arbitration, hit scoring and shot accounting.
// Optional ASTRO_BONUS_SHOT_EN: each accepted hit refunds one shot (saturating at SHOTS_PER_LEVEL).
module astro_game_ctrl #(
    parameter int SHOTS_PER_LEVEL = 8,
    parameter int SCORE_MAX       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fire_req,
    input  logic       bullet_done,
    input  logic       hit_mid,
    input  logic       hit_top,
    output logic [1:0] state,
    output logic       fire_grant,
    output logic       bullet_active,
    output logic [1:0] target_en,
    output logic       target_rearm,
    output logic [1:0] hit_flags,
    output logic [3:0] shots_left,
    output logic [3:0] score,
    output logic       win
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_LEVEL);
    localparam logic [4:0] SCORE_SAT  = 5'(SCORE_MAX);

    state_t     state_q, state_d;
    logic       start_q, fire_q;
    logic       fire_grant_q, fire_grant_d;
    logic       bullet_active_q, bullet_active_d;
    logic       target_rearm_q, target_rearm_d;
    logic [1:0] hit_flags_q, hit_flags_d;
    logic [3:0] shots_left_q, shots_left_d;
    logic [3:0] score_q, score_d;
    logic       win_q, win_d;

    logic       start_rise, fire_rise, in_game, level_clear, out_of_shots;
    logic       acc_mid, acc_top;
    logic [1:0] target_en_c, hit_cnt;
    logic [4:0] score_sum;
`ifdef ASTRO_BONUS_SHOT_EN
    logic [4:0] shots_sum;
`endif

    always_comb begin
        start_rise = start & ~start_q;
        fire_rise  = fire_req & ~fire_q;
        in_game    = (state_q == QGAME_1) || (state_q == QGAME_2);

        case (state_q)
            QGAME_1: target_en_c = 2'b01;
            QGAME_2: target_en_c = 2'b11;
            default: target_en_c = 2'b00;
        endcase

        acc_mid   = in_game & bullet_active_q & target_en_c[0] & ~hit_flags_q[0] & hit_mid;
        acc_top   = in_game & bullet_active_q & target_en_c[1] & ~hit_flags_q[1] & hit_top;
        hit_cnt   = {1'b0, acc_mid} + {1'b0, acc_top};
        score_sum = {1'b0, score_q} + {3'b000, hit_cnt};
`ifdef ASTRO_BONUS_SHOT_EN
        shots_sum = {1'b0, shots_left_q} + {3'b000, hit_cnt};
`endif

        level_clear  = ((state_q == QGAME_1) && hit_flags_q[0]) ||
                       ((state_q == QGAME_2) && (hit_flags_q == 2'b11));
        out_of_shots = in_game && (shots_left_q == 4'd0) && !bullet_active_q && !level_clear;

        state_d         = state_q;
        fire_grant_d    = 1'b0;
        target_rearm_d  = 1'b0;
        bullet_active_d = bullet_active_q;
        hit_flags_d     = hit_flags_q;
        shots_left_d    = shots_left_q;
        score_d         = score_q;
        win_d           = win_q;

        case (state_q)
            QI: begin
                score_d = 4'd0;
                win_d   = 1'b0;
                if (start_rise) begin
                    state_d        = QGAME_1;
                    target_rearm_d = 1'b1;
                    shots_left_d   = SHOTS_INIT;
                    hit_flags_d    = 2'b00;
                end
            end
            QGAME_1, QGAME_2: begin
                if (level_clear) begin
                    bullet_active_d = 1'b0;
                    if (state_q == QGAME_1) begin
                        state_d        = QGAME_2;
                        target_rearm_d = 1'b1;
                        shots_left_d   = SHOTS_INIT;
                        hit_flags_d    = 2'b00;
                    end else begin
                        state_d = QDONE;
                        win_d   = 1'b1;
                    end
                end else if (out_of_shots) begin
                    state_d = QDONE;
                    win_d   = 1'b0;
                end else begin
                    // A hit outranks a simultaneous bullet_done; both retire the bullet.
                    if (acc_mid || acc_top) begin
                        hit_flags_d     = hit_flags_q | {acc_top, acc_mid};
                        score_d         = (score_sum > SCORE_SAT) ? SCORE_SAT[3:0] : score_sum[3:0];
                        bullet_active_d = 1'b0;
`ifdef ASTRO_BONUS_SHOT_EN
                        shots_left_d    = (shots_sum > {1'b0, SHOTS_INIT}) ? SHOTS_INIT : shots_sum[3:0];
`endif
                    end else if (bullet_done) begin
                        bullet_active_d = 1'b0;
                    end
                    if (fire_rise && !bullet_active_q && (shots_left_q != 4'd0)) begin
                        fire_grant_d    = 1'b1;
                        bullet_active_d = 1'b1;
                        shots_left_d    = shots_left_q - 4'd1;
                    end
                end
            end
            QDONE: begin
                bullet_active_d = 1'b0;
                if (!start) begin
                    state_d = QI;
                    score_d = 4'd0;
                    win_d   = 1'b0;
                end
            end
            default: state_d = QI;
        endcase
    end

    // Edge detectors reset high so inputs held across reset release never look like new edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= QI;
            start_q         <= 1'b1;
            fire_q          <= 1'b1;
            fire_grant_q    <= 1'b0;
            bullet_active_q <= 1'b0;
            target_rearm_q  <= 1'b0;
            hit_flags_q     <= 2'b00;
            shots_left_q    <= SHOTS_INIT;
            score_q         <= 4'd0;
            win_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= start;
            fire_q          <= fire_req;
            fire_grant_q    <= fire_grant_d;
            bullet_active_q <= bullet_active_d;
            target_rearm_q  <= target_rearm_d;
            hit_flags_q     <= hit_flags_d;
            shots_left_q    <= shots_left_d;
            score_q         <= score_d;
            win_q           <= win_d;
        end
    end

    assign state         = state_q;
    assign fire_grant    = fire_grant_q;
    assign bullet_active = bullet_active_q;
    assign target_en     = target_en_c;
    assign target_rearm  = target_rearm_q;
    assign hit_flags     = hit_flags_q;
    assign shots_left    = shots_left_q;
    assign score         = score_q;
    assign win           = win_q;

endmodule
